// File: rtl/irq_pending_latch_if.sv
// -----------------------------------------------------------------------------
// irq_pending_latch_if
//   Groups the request-line, encoder and servicing-agent signals of the
//   interrupt pending latch.
//   slave  : the latch itself (consumes requests, drives pend_vec/irq_req/...)
//   master : the surrounding system (request lines, encoder, servicing agent)
//
//   irq_in       raw request lines (rising edge = new request)
//   irq_mask     1 = line hidden from the encoder (pending still kept)
//   pend_vec     pending & ~irq_mask, feeds encoder data_in
//   enc_code     encoder data_out: [2] any valid, [1:0] highest set index
//   irq_req      request to the servicing agent
//   irq_ack      one-cycle acknowledge from the agent
//   active_id    index latched at acknowledge
//   in_service   high from acknowledge until end-of-interrupt
//   eoi          one-cycle end-of-interrupt pulse
//   timeout_flag sticky acknowledge-timeout flag (0 unless the timeout build)
// -----------------------------------------------------------------------------
interface irq_pending_latch_if #(
  parameter int N_IRQ = 4
);
  logic [N_IRQ-1:0] irq_in;
  logic [N_IRQ-1:0] irq_mask;
  logic [N_IRQ-1:0] pend_vec;
  logic [2:0]       enc_code;
  logic             irq_req;
  logic             irq_ack;
  logic [1:0]       active_id;
  logic             in_service;
  logic             eoi;
  logic             timeout_flag;

  modport slave (
    input  irq_in, irq_mask, enc_code, irq_ack, eoi,
    output pend_vec, irq_req, active_id, in_service, timeout_flag
  );

  modport master (
    output irq_in, irq_mask, enc_code, irq_ack, eoi,
    input  pend_vec, irq_req, active_id, in_service, timeout_flag
  );
endinterface

// File: rtl/irq_pending_latch.sv
// -----------------------------------------------------------------------------
// irq_pending_latch
//   Front end of the 4-input priority encoder. Each request line is edge
//   detected into a pending bit; the masked pending vector goes to the encoder
//   and the returned code drives a REQ / acknowledge / EOI handshake with the
//   servicing agent. The acknowledged bit is cleared on the acknowledge edge.
//
//   Ports
//     clk    rising-edge clock
//     rst_n  asynchronous active-low reset
//     bus    irq_pending_latch_if.slave (see the interface header)
//
//   Parameters
//     N_IRQ        number of request lines, must be 4 (encoder width)
//     ACK_TIMEOUT  REQ cycles before giving up on an acknowledge, 2..255
//
//   Build option
//     IRQ_ACK_TIMEOUT_EN  when defined, an un-acknowledged REQ is abandoned
//                         after ACK_TIMEOUT cycles: the offered pending bit is
//                         dropped and the sticky timeout_flag is set. When not
//                         defined REQ waits forever and timeout_flag is 0.
// -----------------------------------------------------------------------------

// One request line: edge detector plus pending bit. A rise on the same edge
// as a clear wins, so a request arriving while its predecessor is being
// acknowledged is never lost.
module irq_pend_cell (
  input  logic clk,
  input  logic rst_n,
  input  logic irq,
  input  logic clr,
  output logic pend
);
  logic irq_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq_d <= 1'b0;
      pend  <= 1'b0;
    end else begin
      irq_d <= irq;
      pend  <= (pend & ~clr) | (irq & ~irq_d);
    end
  end
endmodule

module irq_pending_latch #(
  parameter int N_IRQ       = 4,
  parameter int ACK_TIMEOUT = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  irq_pending_latch_if.slave    bus
);

  // Elaboration-time guards: the encoder is fixed at four inputs and the
  // timeout counter is eight bits wide.
  if (N_IRQ != 4) begin : g_bad_n_irq
    $error("irq_pending_latch: N_IRQ must be 4");
  end
  if (ACK_TIMEOUT < 2 || ACK_TIMEOUT > 255) begin : g_bad_timeout
    $error("irq_pending_latch: ACK_TIMEOUT must be in 2..255");
  end

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } state_t;

  state_t           state, state_nx;
  logic [N_IRQ-1:0] pending;
  logic [N_IRQ-1:0] clr;
  logic [N_IRQ-1:0] sel_onehot;
  logic             enc_any;
  logic [1:0]       enc_idx;
  logic             ack_take;
  logic [1:0]       active_id_q;

  assign enc_any    = bus.enc_code[2];
  assign enc_idx    = bus.enc_code[1:0];
  assign sel_onehot = N_IRQ'(1) << enc_idx;

  // ---------------------------------------------------------------------------
  // Per-line edge detect / pending storage
  // ---------------------------------------------------------------------------
  for (genvar i = 0; i < N_IRQ; i++) begin : g_cell
    irq_pend_cell u_cell (
      .clk   (clk),
      .rst_n (rst_n),
      .irq   (bus.irq_in[i]),
      .clr   (clr[i]),
      .pend  (pending[i])
    );
  end

  // Encoder path is purely combinational; masking hides but never clears.
  assign bus.pend_vec = pending & ~bus.irq_mask;

`ifdef IRQ_ACK_TIMEOUT_EN
  logic [7:0] tmo_cnt;
  logic       tmo_hit;
  logic       tmo_flag_q;
`endif

  // ---------------------------------------------------------------------------
  // Handshake FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    clr      = '0;
    ack_take = 1'b0;
`ifdef IRQ_ACK_TIMEOUT_EN
    tmo_hit  = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (enc_any) state_nx = REQ;
      end
      REQ: begin
        // Nothing left to offer (typically the line got masked): withdraw.
        if (!enc_any) begin
          state_nx = IDLE;
        end else if (bus.irq_ack) begin
          // The code seen on this very edge is what gets serviced.
          state_nx = SERVICE;
          ack_take = 1'b1;
          clr      = sel_onehot;
`ifdef IRQ_ACK_TIMEOUT_EN
        end else if (tmo_cnt == 8'(ACK_TIMEOUT - 1)) begin
          // Acknowledge wins over timeout because it is tested first.
          state_nx = IDLE;
          tmo_hit  = 1'b1;
          clr      = sel_onehot;
`endif
        end
      end
      SERVICE: begin
        if (bus.eoi) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // active_id is only updated by an acknowledge, so it keeps showing the last
  // serviced line after EOI.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        active_id_q <= 2'd0;
    else if (ack_take) active_id_q <= enc_idx;
  end

`ifdef IRQ_ACK_TIMEOUT_EN
  // Counts REQ cycles; restarted on every entry into REQ.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                tmo_cnt <= 8'd0;
    else if (state != REQ && state_nx == REQ)  tmo_cnt <= 8'd0;
    else if (state == REQ)                     tmo_cnt <= tmo_cnt + 8'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       tmo_flag_q <= 1'b0;
    else if (tmo_hit) tmo_flag_q <= 1'b1;
  end

  assign bus.timeout_flag = tmo_flag_q;
`else
  assign bus.timeout_flag = 1'b0;
`endif

  // Outputs are decodes of the registered state, so they change one cycle
  // after the deciding edge and carry no combinational path from inputs.
  assign bus.irq_req    = (state == REQ);
  assign bus.in_service = (state == SERVICE);
  assign bus.active_id  = active_id_q;

endmodule

// File: tb/tb_irq_pending_latch.sv
// -----------------------------------------------------------------------------
// tb_irq_pending_latch
//   Stimulus drives inputs on the falling edge, steps a behavioural model of
//   the interrupt rules and queues the outputs expected after the next rising
//   edge. A monitor pops and compares one entry per rising edge. A small
//   encoder model closes the pend_vec -> enc_code loop.
// -----------------------------------------------------------------------------
module tb_irq_pending_latch;
  localparam int T_ACK = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  irq_pending_latch_if #(.N_IRQ(4)) bus ();

  irq_pending_latch #(.N_IRQ(4), .ACK_TIMEOUT(T_ACK)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Encoder model: bit 2 = any set, bits 1:0 = highest set index.
  function automatic logic [2:0] prienc(input logic [3:0] v);
    logic [2:0] r;
    r = 3'b000;
    for (int i = 0; i < 4; i++) if (v[i]) r = {1'b1, 2'(i)};
    return r;
  endfunction
  assign bus.enc_code = prienc(bus.pend_vec);

  // ---------------------------------------------------------------------------
  // Scoreboard and checks
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [3:0] pv;
    logic       req;
    logic       svc;
    logic [1:0] id;
    logic       tf;
  } exp_t;

  exp_t sb[$];
  int   n_tot  = 0;
  int   n_pass = 0;

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
  endtask

  // ---------------------------------------------------------------------------
  // Reference model (phase: 0 idle, 1 requesting, 2 being serviced)
  // ---------------------------------------------------------------------------
  bit [3:0] m_pend, m_last_in;
  int       m_phase, m_wait;
  bit [1:0] m_id;
  bit       m_tf;

  function automatic int top_bit(input bit [3:0] v);
    int r = 0;
    for (int i = 0; i < 4; i++) if (v[i]) r = i;
    return r;
  endfunction

  task automatic model_reset();
    m_pend = '0; m_last_in = '0; m_phase = 0; m_wait = 0; m_id = '0; m_tf = 1'b0;
  endtask

  task automatic model_step(input bit [3:0] in, input bit [3:0] mask, input bit ack, input bit eoi_i);
    bit [3:0] vis, drop;
    int       top;
    vis  = m_pend & ~mask;
    top  = top_bit(vis);
    drop = '0;
    if (m_phase == 0) begin
      if (vis != 0) begin m_phase = 1; m_wait = 0; end
    end else if (m_phase == 1) begin
      if (vis == 0) m_phase = 0;
      else if (ack) begin m_phase = 2; m_id = 2'(top); drop[top] = 1'b1; end
      else begin
`ifdef IRQ_ACK_TIMEOUT_EN
        if (m_wait == T_ACK - 1) begin m_phase = 0; drop[top] = 1'b1; m_tf = 1'b1; end
        else m_wait++;
`endif
      end
    end else begin
      if (eoi_i) m_phase = 0;
    end
    m_pend    = (m_pend & ~drop) | (in & ~m_last_in);
    m_last_in = in;
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  bit rst_req = 1'b1;

  task automatic cyc(input logic [3:0] in, input logic [3:0] mask, input bit ack, input bit eoi_i);
    exp_t e;
    @(negedge clk);
    rst_n        = ~rst_req;
    bus.irq_in   = in;
    bus.irq_mask = mask;
    bus.irq_ack  = ack;
    bus.eoi      = eoi_i;
    if (rst_req) model_reset();
    else         model_step(in, mask, ack, eoi_i);
    e.pv  = m_pend & ~mask;
    e.req = (m_phase == 1);
    e.svc = (m_phase == 2);
    e.id  = m_id;
    e.tf  = m_tf;
    sb.push_back(e);
  endtask

  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  task automatic chk_reset_now(input string tag);
    chk({tag, "_pend_vec"},  8'(bus.pend_vec),     8'h0);
    chk({tag, "_irq_req"},   8'(bus.irq_req),      8'h0);
    chk({tag, "_in_svc"},    8'(bus.in_service),   8'h0);
    chk({tag, "_active_id"}, 8'(bus.active_id),    8'h0);
    chk({tag, "_tmo_flag"},  8'(bus.timeout_flag), 8'h0);
  endtask

  // ---------------------------------------------------------------------------
  // Monitor
  // ---------------------------------------------------------------------------
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("sb_pend_vec",  8'(bus.pend_vec),     8'(e.pv));
        chk("sb_irq_req",   8'(bus.irq_req),      8'(e.req));
        chk("sb_in_svc",    8'(bus.in_service),   8'(e.svc));
        chk("sb_active_id", 8'(bus.active_id),    8'(e.id));
        chk("sb_tmo_flag",  8'(bus.timeout_flag), 8'(e.tf));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got running want done");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Test sequence
  // ---------------------------------------------------------------------------
  initial begin
    logic [3:0] r_in, r_mask;
    bit         r_ack, r_eoi;

    bus.irq_in = '0; bus.irq_mask = '0; bus.irq_ack = 1'b0; bus.eoi = 1'b0;
    model_reset();

    // Reset held with quiet lines.
    rst_req = 1'b1;
    repeat (10) cyc(4'h0, 4'h0, 0, 0);
    settle();
    chk_reset_now("rst");
    rst_req = 1'b0;
    repeat (2) cyc(4'h0, 4'h0, 0, 0);

    // Two lines at once, serviced highest first.
    cyc(4'b1010, 4'h0, 0, 0);
    settle(); chk("dual_pend_vec", 8'(bus.pend_vec), 8'h0a);
              chk("dual_no_req_yet", 8'(bus.irq_req), 8'h0);
    cyc(4'b0000, 4'h0, 0, 0);
    settle(); chk("dual_req", 8'(bus.irq_req), 8'h1);
    cyc(4'b0000, 4'h0, 1, 0);
    settle(); chk("dual_ack_id", 8'(bus.active_id), 8'h3);
              chk("dual_ack_pv", 8'(bus.pend_vec), 8'h02);
              chk("dual_ack_svc", 8'(bus.in_service), 8'h1);
    cyc(4'b0000, 4'h0, 0, 0);
    cyc(4'b0000, 4'h0, 0, 1);
    settle(); chk("dual_eoi_idle", 8'(bus.in_service), 8'h0);
              chk("dual_id_held", 8'(bus.active_id), 8'h3);
    cyc(4'b0000, 4'h0, 0, 0);
    settle(); chk("dual_req2", 8'(bus.irq_req), 8'h1);
    cyc(4'b0000, 4'h0, 1, 0);
    settle(); chk("dual_ack2_id", 8'(bus.active_id), 8'h1);
    cyc(4'b0000, 4'h0, 0, 1);

    // Level-held line pends only once.
    cyc(4'b0100, 4'h0, 0, 0);
    cyc(4'b0100, 4'h0, 0, 0);
    cyc(4'b0100, 4'h0, 1, 0);
    repeat (17) cyc(4'b0100, 4'h0, 0, 0);
    cyc(4'b0100, 4'h0, 0, 1);
    cyc(4'b0000, 4'h0, 0, 0);
    settle(); chk("hold_pend_clear", 8'(bus.pend_vec), 8'h0);
              chk("hold_no_req", 8'(bus.irq_req), 8'h0);

    // Masking the only pending line withdraws the request.
    cyc(4'b0001, 4'h0, 0, 0);
    cyc(4'b0000, 4'h0, 0, 0);
    settle(); chk("mask_req_on", 8'(bus.irq_req), 8'h1);
    cyc(4'b0000, 4'b0001, 0, 0);
    settle(); chk("mask_req_drop", 8'(bus.irq_req), 8'h0);
              chk("mask_pv_hidden", 8'(bus.pend_vec), 8'h0);
    cyc(4'b0000, 4'h0, 0, 0);
    settle(); chk("unmask_req", 8'(bus.irq_req), 8'h1);
    cyc(4'b0000, 4'h0, 1, 0);
    settle(); chk("unmask_ack_id", 8'(bus.active_id), 8'h0);
    cyc(4'b0000, 4'h0, 0, 1);

    // New rise on the acknowledge edge of the same line: set wins.
    cyc(4'b1000, 4'h0, 0, 0);
    cyc(4'b0000, 4'h0, 0, 0);
    cyc(4'b1000, 4'h0, 1, 0);
    settle(); chk("setwin_pv", 8'(bus.pend_vec), 8'h08);
              chk("setwin_id", 8'(bus.active_id), 8'h3);
              chk("setwin_svc", 8'(bus.in_service), 8'h1);
    cyc(4'b0000, 4'h0, 0, 1);
    cyc(4'b0000, 4'h0, 0, 0);
    cyc(4'b0000, 4'h0, 1, 0);
    cyc(4'b0000, 4'h0, 0, 1);
    cyc(4'b0000, 4'h0, 0, 0);

    // Un-acknowledged request.
    cyc(4'b0100, 4'h0, 0, 0);
    cyc(4'b0000, 4'h0, 0, 0);
    repeat (3) cyc(4'b0000, 4'h0, 0, 0);
    settle(); chk("tmo_still_req", 8'(bus.irq_req), 8'h1);
    cyc(4'b0000, 4'h0, 0, 0);
    settle();
`ifdef IRQ_ACK_TIMEOUT_EN
    chk("tmo_idle", 8'(bus.irq_req), 8'h0);
    chk("tmo_pend_drop", 8'(bus.pend_vec), 8'h0);
    chk("tmo_flag", 8'(bus.timeout_flag), 8'h1);
`else
    chk("notmo_req", 8'(bus.irq_req), 8'h1);
    chk("notmo_pend", 8'(bus.pend_vec), 8'h04);
    chk("notmo_flag", 8'(bus.timeout_flag), 8'h0);
`endif

    // Reset in the middle of a request.
    cyc(4'b0010, 4'h0, 0, 0);
    cyc(4'b0000, 4'h0, 0, 0);
    settle(); chk("midrst_req", 8'(bus.irq_req), 8'h1);
    rst_req = 1'b1;
    cyc(4'b0000, 4'h0, 0, 0);
    #1;
    chk_reset_now("midrst");
    repeat (2) cyc(4'b0000, 4'h0, 0, 0);
    rst_req = 1'b0;
    cyc(4'b0000, 4'h0, 0, 0);

    // Randomised traffic against the model.
    r_in = '0;
    for (int n = 0; n < 600; n++) begin
      r_in   = 4'($urandom) & 4'($urandom);
      r_mask = ($urandom_range(0, 9) == 0) ? 4'($urandom) : 4'h0;
      if (m_phase == 1)
        r_ack = ((m_pend & ~r_mask) != 0) && ($urandom_range(0, 2) == 0);
      else
        r_ack = ($urandom_range(0, 7) == 0);
      r_eoi = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 199) == 0) rst_req = 1'b1;
      cyc(r_in, r_mask, r_ack, r_eoi);
      rst_req = 1'b0;
    end

    cyc(4'h0, 4'h0, 0, 0);
    repeat (3) @(posedge clk);
    #3;
    chk("sb_drained", 8'(sb.size()), 8'h0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
